// File: rtl/simm_pkg.sv
// Shared types and constants for the SIMM controller front end and its
// companion decoders.
package simm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    ACK  = 2'b11
  } state_t;

  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // 68030 SIZ1:SIZ0 encodings
  typedef enum logic [1:0] {
    SIZ_LONG   = 2'b00,
    SIZ_BYTE   = 2'b01,
    SIZ_WORD   = 2'b10,
    SIZ_TRIPLE = 2'b11
  } siz_t;

endpackage

// File: rtl/simm_lane_decode.sv
// 68030 dynamic bus sizing: SIZ1:SIZ0 and A1:A0 to the four byte-lane
// selects of a 32-bit port ([3] = D31:24, [0] = D7:0).
module simm_lane_decode
  import simm_pkg::*;
(
  input  logic [1:0] siz,
  input  logic [1:0] a,
  output logic [3:0] byte_selects
);

  logic s1, s0, a1, a0;

  assign s1 = siz[1];
  assign s0 = siz[0];
  assign a1 = a[1];
  assign a0 = a[0];

  assign byte_selects[3] = !a1 && !a0;
  assign byte_selects[2] = !a1 && (a0 || !s0 || s1);
  assign byte_selects[1] = (a1 && !a0) || (!a1 && !s0 && !s1) ||
                           (!a1 && s0 && s1) || (!a1 && a0 && !s0);
  assign byte_selects[0] = (a1 && a0) || (a0 && s0 && s1) ||
                           (!s0 && !s1) || (a1 && s1);

endmodule

// File: rtl/simm_bus_interface.sv
// CPU-side front end of the SIMM controller: qualifies window hits, holds a
// frozen request until the controller completes, and terminates the 68030
// cycle with DSACK (32-bit port) or BERR on timeout.
module simm_bus_interface
  import simm_pkg::*;
#(
  parameter int         DECODE_HI      = 31,
  parameter int         DECODE_LO      = 28,
  parameter logic [DECODE_HI-DECODE_LO:0] BASE_PREFIX = 4'h1,
  parameter int         BANK_BIT       = 26,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [1:0]  siz,
  input  logic        rw,
  input  logic        as_n,
  input  logic        ds_n,
  input  logic        waitstate,
  output logic        cs,
  output logic        read,
  output logic        write,
  output logic        bank_addr,
  output logic [3:0]  byte_selects,
  output logic [1:0]  dsack_n,
  output logic        berr_n
);

  state_t     state, next_state;
  logic [7:0] count, count_d;
  logic       abort, abort_d;
  logic       cs_d, read_d, write_d, bank_d, berr_d;
  logic [3:0] sel_d, lanes;
  logic [1:0] dsack_d;
  logic       hit, start, aborted, timeout, done;

  // Only the window field, bank bit and A1:A0 matter; fold the rest away.
  logic addr_unused;
  assign addr_unused = ^addr;

  assign hit     = !as_n && (addr[DECODE_HI:DECODE_LO] == BASE_PREFIX);
  // Writes wait for DS so the controller never sees a write before its data.
  assign start   = hit && (rw || !ds_n);
  assign aborted = abort || as_n;
  assign timeout = (count == TIMEOUT_CYCLES);
  assign done    = !waitstate || timeout;

  simm_lane_decode u_lane_decode (
    .siz          (siz),
    .a            (addr[1:0]),
    .byte_selects (lanes)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      abort        <= 1'b0;
      cs           <= 1'b0;
      read         <= 1'b0;
      write        <= 1'b0;
      bank_addr    <= 1'b0;
      byte_selects <= '0;
      dsack_n      <= DSACK_NONE;
      berr_n       <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state        <= next_state;
      count        <= count_d;
      abort        <= abort_d;
      cs           <= cs_d;
      read         <= read_d;
      write        <= write_d;
      bank_addr    <= bank_d;
      byte_selects <= sel_d;
      dsack_n      <= dsack_d;
      berr_n       <= berr_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     next_state = WAIT;
      WAIT:    if (done) next_state = aborted ? IDLE : ACK;
      ACK:     if (as_n) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cs_d    = cs;
    read_d  = read;
    write_d = write;
    bank_d  = bank_addr;
    sel_d   = byte_selects;
    dsack_d = dsack_n;
    berr_d  = berr_n;
    count_d = count;
    abort_d = abort;
    unique case (state)
      IDLE: if (start) begin
        cs_d    = 1'b1;
        read_d  = rw;
        write_d = !rw;
        bank_d  = addr[BANK_BIT];
        sel_d   = lanes;
        count_d = '0;
        abort_d = 1'b0;
      end
      REQ: abort_d = aborted;
      WAIT: begin
        abort_d = aborted;
        if (done) begin
          cs_d    = 1'b0;
          read_d  = 1'b0;
          write_d = 1'b0;
          sel_d   = '0;
          // An abandoned CPU cycle gets no termination; completion beats timeout.
          if (!aborted) begin
            if (!waitstate) dsack_d = DSACK_32;
            else            berr_d  = 1'b0;
          end
        end else begin
          count_d = count + 8'd1;
        end
      end
      ACK: if (as_n) begin
        dsack_d = DSACK_NONE;
        berr_d  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/simm_bus_interface.md
Name: simm_bus_interface

Overview:
- Upstream front end of simm_controller.
- Qualifies 68030 bus cycles that hit the SIMM window, decodes SIZ/A1:A0 into the four byte-lane selects, and holds the cs/read/write/bank_addr/byte_selects request stable until the controller drops waitstate.
- Terminates the CPU cycle with 32-bit DSACK, or with BERR on timeout.
- All CPU inputs are synchronous to clock, which is the shared CPU clock.

Parameters:
- DECODE_HI, 31, MSB of the address field compared for the window hit.
- DECODE_LO, 28, LSB of that field.
- BASE_PREFIX, 4'h1, value addr[DECODE_HI:DECODE_LO] must equal for a hit.
- BANK_BIT, 26, address bit driven onto bank_addr.
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before BERR; 8-bit counter.

Ports:
- clock  in  1  system/CPU clock.
- reset  in  1  asynchronous, active-high.
- addr  in  32  CPU address.
- siz  in  2  CPU SIZ1:SIZ0.
- rw  in  1  1 = read, 0 = write.
- as_n  in  1  address strobe, active-low.
- ds_n  in  1  data strobe, active-low.
- waitstate  in  1  from simm_controller; high while the access is not complete.
- cs  out  1  request to simm_controller.
- read  out  1  read request.
- write  out  1  write request.
- bank_addr  out  1  SIMM bank select.
- byte_selects  out  4  lane enables; [3]=D31:24, [0]=D7:0.
- dsack_n  out  2  cycle termination; 2'b00 = 32-bit port.
- berr_n  out  1  bus error, active-low.

Behaviour:
- Reset (async, immediate, also mid-cycle):
  - state=IDLE.
  - cs=read=write=bank_addr=0, byte_selects=0.
  - dsack_n=2'b11, berr_n=1, timeout counter=0.
- All outputs are registered.
- hit = !as_n && addr[DECODE_HI:DECODE_LO]==BASE_PREFIX.
- Lane decode (combinational, registered on request start):
  - [3] = !A1&!A0
  - [2] = !A1&(A0 | !SIZ0 | SIZ1)
  - [1] = (A1&!A0) | (!A1&!SIZ0&!SIZ1) | (!A1&SIZ0&SIZ1) | (!A1&A0&!SIZ0)
  - [0] = (A1&A0) | (A0&SIZ0&SIZ1) | (!SIZ0&!SIZ1) | (A1&SIZ1)
- States:
  - IDLE: a read starts on hit&&rw. A write starts on hit&&!rw&&!ds_n; write data is valid only once DS is low. On start, register cs=1, read=rw, write=!rw, bank_addr=addr[BANK_BIT], byte_selects=decode, clear counter, go to REQ.
  - REQ: one cycle. waitstate is ignored here because the controller has not yet registered cs. Go to WAIT.
  - WAIT: counter increments each cycle.
    - waitstate==0: drop cs/read/write/byte_selects to 0, set dsack_n=2'b00, go to ACK.
    - counter reaches TIMEOUT_CYCLES while waitstate is high: drop the request, set berr_n=0, go to ACK.
    - waitstate low and timeout in the same cycle: normal completion wins and BERR is not asserted.
  - ACK: hold dsack_n/berr_n until as_n==1, then release both high and return to IDLE. No new request may start in the cycle as_n rises.
- Request fields are frozen from REQ through WAIT; addr/siz changes are ignored.
- as_n rising early (in REQ or WAIT): the SIMM access still completes (cs held until waitstate low), DSACK is never asserted, then return straight to IDLE.
- Refresh inside the controller only extends waitstate. It needs no special handling and is bounded by the timeout.
- Latency: a read with zero controller wait inserts 3 clocks from AS low to DSACK low (IDLE→REQ→WAIT→ACK).

Decomposition:
- Shared package simm_pkg holds:
  - state enum: IDLE, REQ, WAIT, ACK
  - DSACK_32 = 2'b00, DSACK_NONE = 2'b11
  - SIZ codes: BYTE=01, WORD=10, TRIPLE=11, LONG=00
- One natural sub-module: simm_lane_decode (purely combinational SIZ/A1:A0 → byte_selects), reusable by the I/O decoder.

Test Plan:
- Long read at 0x1000_0000 (siz=00, rw=1), waitstate high for 5 cycles → cs=1, read=1, byte_selects=4'b1111, bank_addr=0; dsack_n=00 one cycle after waitstate falls; released when as_n rises.
- Byte write at 0x1400_0003 (siz=01, rw=0), ds_n one cycle after as_n → no cs until ds_n low; byte_selects=4'b0001, write=1, bank_addr=1.
- Lane table sweep, all siz × A1:A0 → word@2=0011, word@0=1100, triple@1=0111, long@2=0011, byte@1=0100.
- Miss at 0x2000_0000 → cs never asserted, dsack_n stays 11.
- waitstate held high 300 cycles → berr_n=0 after TIMEOUT_CYCLES+1 WAIT cycles, cs=0, dsack_n=11; berr_n released when as_n rises.
- Reset asserted during WAIT with cs=1 → all outputs return to reset values immediately (async); next hit after reset starts cleanly from IDLE.
